// File: rtl/demux16_buf_pkg.sv
// demux16_buf_pkg: shared channel count, select width and channel mask type
package demux_pkg;
  localparam int NUM_CH = 16;
  localparam int SEL_W = 4;
  typedef logic [NUM_CH-1:0] ch_mask_t;
endpackage

// File: rtl/demux16_buf_if.sv
// demux16_buf_if: producer handshake plus 16 consumer handshakes of the distributor
interface demux16_buf_if #(parameter int N = 1);
  import demux_pkg::*;
  logic in_valid;
  logic in_ready;
  logic [N-1:0] in_data;
  logic [SEL_W-1:0] s;
  ch_mask_t out_valid;
  ch_mask_t out_ready;
  logic [NUM_CH*N-1:0] out_data;
  logic busy;
  modport master (output in_valid, in_data, s, out_ready, input in_ready, out_valid, out_data, busy);
  modport slave (input in_valid, in_data, s, out_ready, output in_ready, out_valid, out_data, busy);
endinterface

// File: rtl/demux16_buf_decoder4to16.sv
// decoder4to16: one-hot channel mask from a 4-bit select, all zero when disabled
module decoder4to16
  import demux_pkg::*;
(
  input  logic [SEL_W-1:0] sel,
  input  logic             en,
  output ch_mask_t         mask
);
  // single set bit at the selected channel when enabled
  always_comb mask = en ? ch_mask_t'(1) << sel : '0;
endmodule

// File: rtl/demux16_buf.sv
// demux16_buf: 16-way distributor with a one-entry holding register per channel; DEMUX16_BYPASS_EN adds a cut-through path
module demux16_buf
  import demux_pkg::*;
#(
  parameter int N = 1
) (
  input logic clk,
  input logic rst,
  demux16_buf_if.slave bus
);
  ch_mask_t full_v, load_v, byp_v;
  logic byp;
  // accept depends only on the selected channel, so other full channels never stall the producer
  assign bus.in_ready = ~full_v[bus.s] | bus.out_ready[bus.s];
`ifdef DEMUX16_BYPASS_EN
  // an empty channel whose consumer is ready takes the word directly, leaving the register untouched
  assign byp = bus.in_valid & ~full_v[bus.s] & bus.out_ready[bus.s];
`else
  assign byp = 1'b0;
`endif
  decoder4to16 u_load (.sel(bus.s), .en(bus.in_valid & bus.in_ready & ~byp), .mask(load_v));
  decoder4to16 u_byp (.sel(bus.s), .en(byp), .mask(byp_v));
  assign bus.out_valid = full_v | byp_v;
  assign bus.busy = |full_v;
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic full_q;
    logic [N-1:0] data_q;
    // load wins over drain so a channel streams one word per cycle; data only changes on load
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        full_q <= 1'b0;
        data_q <= '0;
      end else begin
        full_q <= load_v[k] | (full_q & ~bus.out_ready[k]);
        if (load_v[k]) data_q <= bus.in_data;
      end
    assign full_v[k] = full_q;
    assign bus.out_data[k*N +: N] = byp_v[k] ? bus.in_data : data_q;
  end
endmodule

// File: tb/tb_demux16_buf.sv
// tb_demux16_buf: randomized and directed checks of demux16_buf against a per-channel queue model
module tb_demux16_buf;
  logic clk = 0, rst = 1;
  demux16_buf_if #(.N(8)) bus ();
  demux16_buf #(.N(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0;
  logic [15:0] mf = '0;
  logic [7:0] md [16];
  logic lv = 0, lr = 1;
  logic [3:0] ls = 0;
  logic [7:0] ld = 0;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  task automatic cycle(input logic v, input logic [3:0] sel, input logic [7:0] d, input logic [15:0] ordy);
    logic rdy, byp;
    logic [15:0] ev;
    logic [127:0] ed;
    @(negedge clk);
    bus.in_valid = v; bus.s = sel; bus.in_data = d; bus.out_ready = ordy;
    #1;
    rdy = !mf[sel] || ordy[sel];
    byp = 0;
`ifdef DEMUX16_BYPASS_EN
    byp = v && !mf[sel] && ordy[sel];
`endif
    ev = mf;
    ed = '0;
    for (int k = 0; k < 16; k++) ed[k*8 +: 8] = md[k];
    if (byp) begin ev[sel] = 1; ed[sel*8 +: 8] = d; end
    check("in_ready", 128'(bus.in_ready), 128'(rdy));
    check("out_valid", 128'(bus.out_valid), 128'(ev));
    check("out_data", bus.out_data, ed);
    check("busy", 128'(bus.busy), 128'(mf != 0));
    lv = v; lr = rdy; ls = sel; ld = d;
    @(posedge clk);
    for (int k = 0; k < 16; k++)
      if (v && rdy && !byp && sel == k) begin mf[k] = 1; md[k] = d; end
      else if (mf[k] && ordy[k]) mf[k] = 0;
  endtask

  task automatic model_reset();
    mf = '0;
    for (int k = 0; k < 16; k++) md[k] = '0;
    lv = 0; lr = 1;
  endtask

  initial begin
    logic v;
    logic [3:0] sel;
    logic [7:0] d;
    model_reset();
    bus.in_valid = 0; bus.s = 0; bus.in_data = 0; bus.out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 128'(bus.out_valid), 128'(0));
    check("rst_data", bus.out_data, 128'(0));
    check("rst_busy", 128'(bus.busy), 128'(0));
    @(negedge clk) rst = 0;
    cycle(1, 7, 8'hA5, 16'h0);
    #1 check("single_valid", 128'(bus.out_valid), 128'(16'h0080));
    check("single_data", 128'(bus.out_data[63:56]), 128'(8'hA5));
    repeat (5) cycle(0, 0, 0, 16'h0);
    cycle(0, 0, 0, 16'h0080);
    #1 check("single_drained", 128'(bus.out_valid), 128'(0));
    cycle(1, 2, 8'h11, 16'h0);
    cycle(1, 2, 8'h22, 16'h0);
    check("bp_hold", 128'(bus.out_data[23:16]), 128'(8'h11));
    cycle(1, 5, 8'h55, 16'h0);
    #1 check("bp_other", 128'(bus.out_data[47:40]), 128'(8'h55));
    for (int i = 1; i <= 16; i++) begin
      cycle(1, 0, 8'(i), 16'hFFFF);
`ifndef DEMUX16_BYPASS_EN
      #1 check("stream_data", 128'(bus.out_data[7:0]), 128'(i));
      check("stream_valid", 128'(bus.out_valid[0]), 128'(1));
`endif
    end
    cycle(0, 0, 0, 16'hFFFF);
    for (int k = 0; k < 16; k++) cycle(1, 4'(k), 8'(k * 3 + 1), 16'h0);
    #1 check("all_full", 128'(bus.out_valid), 128'(16'hFFFF));
    cycle(0, 0, 0, 16'hFFFF);
    #1 check("all_drained", 128'(bus.out_valid), 128'(0));
    check("all_idle", 128'(bus.busy), 128'(0));
`ifdef DEMUX16_BYPASS_EN
    cycle(1, 4, 8'h3C, 16'h0010);
    cycle(0, 0, 0, 16'h0);
`endif
    for (int i = 0; i < 2000; i++) begin
      if (lv && !lr) begin v = 1; sel = ls; d = ld; end
      else begin v = ($urandom_range(3) != 0); sel = 4'($urandom_range(15)); d = 8'($urandom); end
      cycle(v, sel, d, ($urandom_range(1) != 0) ? 16'($urandom) : 16'($urandom) & 16'($urandom) & 16'($urandom));
    end
    cycle(1, 3, 8'h33, 16'h0);
    cycle(1, 9, 8'h99, 16'h0);
    @(negedge clk);
    bus.in_valid = 0; bus.out_ready = 0;
    #1 rst = 1;
    #1;
    check("arst_valid", 128'(bus.out_valid), 128'(0));
    check("arst_busy", 128'(bus.busy), 128'(0));
    check("arst_data", bus.out_data, 128'(0));
    model_reset();
    @(negedge clk) rst = 0;
    cycle(1, 9, 8'h5A, 16'h0);
    cycle(0, 0, 0, 16'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
